// File: rtl/bounce_gen.sv
// Mechanical-contact bounce emulator: a clean level command becomes a burst of pseudo-random edges that then settles.
// Latency: 1 cycle from a press change to the first edge (or to btn_out in pass-through); each burst lasts BOUNCE_CYCLES cycles.
// Backpressure: none. press changes during a burst are ignored, and a pending change starts a new burst one cycle after done.
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   press      clean commanded button level
//   bounce_en  1 = emulate bounce, 0 = registered pass-through
//   btn_out    emulated raw contact level (registered)
//   busy       high while a burst is in progress
//   done       one-cycle pulse when a burst ends with btn_out settled
//   toggles    level changes emitted in the current/last burst (saturating)
module bounce_gen #(
    parameter int unsigned BOUNCE_CYCLES = 1000000,
    parameter int unsigned MIN_GAP       = 4,
    parameter int unsigned GAP_BITS      = 12,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        press,
    input  logic        bounce_en,
    output logic        btn_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] toggles
);

    localparam int unsigned WIN_W = $clog2(BOUNCE_CYCLES);
    // Wide enough to hold MIN_GAP + 2^GAP_BITS - 1 without overflow.
    localparam int unsigned GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS));

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BOUNCE_CYCLES - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_BOUNCE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIN_W-1:0] win_q,   win_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic [15:0]      lfsr_q,  lfsr_d;
    logic [15:0]      tog_q,   tog_d;
    logic             btn_q,   btn_d;
    logic             tgt_q,   tgt_d;
    logic             done_q,  done_d;

    logic [GAP_W-1:0] gap_load;
    logic [15:0]      tog_inc;
    logic             lfsr_fb;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11.
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign gap_load = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[GAP_BITS-1:0]);
    assign tog_inc  = (tog_q == 16'hFFFF) ? tog_q : tog_q + 16'd1;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        state_d = state_q;
        win_d   = win_q;
        gap_d   = gap_q;
        btn_d   = btn_q;
        tgt_d   = tgt_q;
        tog_d   = tog_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bounce_en) begin
                    btn_d = press;
                    tgt_d = press;
                end else if (press != tgt_q) begin
                    // Target is latched here and frozen for the whole burst.
                    tgt_d   = press;
                    state_d = S_BOUNCE;
                    btn_d   = ~btn_q;
                    tog_d   = 16'd1;
                    win_d   = '0;
                    gap_d   = gap_load;
                end
            end
            default: begin
                win_d = win_q + 1'b1;
                if (gap_q == '0) begin
                    btn_d = ~btn_q;
                    tog_d = tog_inc;
                    gap_d = gap_load;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
                if (win_q == WIN_LAST) begin
                    // Settle wins over a coincident random toggle; only a real
                    // level change at this edge is counted.
                    btn_d   = tgt_q;
                    tog_d   = (btn_q != tgt_q) ? tog_inc : tog_q;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            gap_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            tog_q   <= '0;
            btn_q   <= 1'b0;
            tgt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            tog_q   <= tog_d;
            btn_q   <= btn_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign btn_out = btn_q;
    assign busy    = (state_q == S_BOUNCE);
    assign done    = done_q;
    assign toggles = tog_q;

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Synthesizable bounce emulator: turns a clean level command into a realistic mechanical-contact waveform.
- Pseudo-random toggling for a fixed window, then settles on the commanded level.
- Sits on the stimulus side of the push-button path. Drives the debouncer's raw input on-board (via switch-selected mux) and in simulation, so debounce timing can be exercised without physical buttons.
- `done` / `toggles` outputs let a checker correlate debouncer output with the generated burst.

Parameters:
- BOUNCE_CYCLES, 1000000, length of each bounce window in clk cycles (≥2).
- MIN_GAP, 4, minimum reload value of the inter-toggle gap counter.
- GAP_BITS, 12, number of LFSR bits added to MIN_GAP for the random gap.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset, sampled on posedge clk
- press  input  1  clean commanded button level
- bounce_en  input  1  1 = emulate bounce; 0 = pass-through mode
- btn_out  output  1  emulated raw contact signal (registered)
- busy  output  1  high while a bounce burst is in progress
- done  output  1  one-cycle pulse when a burst ends and btn_out has settled
- toggles  output  16  edges emitted in current/last burst, saturating at 16'hFFFF

Behaviour:
- Reset: when rstn=0 at a clk edge:
  - btn_out=0, tgt=0, busy=0, done=0, toggles=0.
  - state=IDLE, win=0, gap=0, lfsr=LFSR_SEED.
  - Applies mid-burst; the burst is abandoned with no done pulse.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11.
  - Shifts every non-reset cycle regardless of state.
  - Gap load value = MIN_GAP + lfsr[GAP_BITS-1:0], using the current lfsr value.
- States: IDLE and BOUNCE. busy = (state==BOUNCE), registered.
- done: defaults to 0 every cycle; asserted for exactly one cycle per completed burst.
- IDLE with bounce_en=0:
  - btn_out<=press and tgt<=press (1-cycle latency).
  - No done, toggles unchanged.
- IDLE with bounce_en=1 and press==tgt: hold all outputs.
- IDLE with bounce_en=1 and press!=tgt, at the next edge:
  - tgt<=press, state<=BOUNCE.
  - btn_out<=~btn_out (first edge), toggles<=1.
  - win<=0, gap<=load value.
- BOUNCE, each cycle:
  - win<=win+1.
  - If gap==0: btn_out<=~btn_out, toggles<=toggles+1 (saturating), gap<=load value.
  - Otherwise gap<=gap-1.
  - Result: toggle spacing lies in [MIN_GAP+1, MIN_GAP+2^GAP_BITS] cycles.
- BOUNCE end, on the edge where win==BOUNCE_CYCLES-1:
  - btn_out<=tgt regardless of toggle parity; settle overrides a coincident toggle, and toggles counts only actual level changes.
  - state<=IDLE, done<=1.
  - Total burst length is exactly BOUNCE_CYCLES cycles with busy=1.
- Simultaneous / changing inputs during BOUNCE:
  - press changes are ignored; tgt is frozen for the burst.
  - If press!=tgt on return to IDLE, a new burst starts on the next edge, so busy drops for exactly 1 cycle.
  - bounce_en deasserted mid-burst takes effect only in IDLE; the current burst completes.
- Widths:
  - win is $clog2(BOUNCE_CYCLES) bits.
  - gap is wide enough for MIN_GAP + 2^GAP_BITS - 1; the sum must not overflow.
- toggles holds its value after done until the next burst starts.

Test Plan (BOUNCE_CYCLES=64, MIN_GAP=2, GAP_BITS=3):
- Reset then idle 10 cycles:
  - Expect btn_out=0, busy=0, done=0, toggles=0.
  - lfsr sequence from 16'hACE1 matches the reference model.
- bounce_en=1, press 0->1 at cycle T:
  - At T+1: busy=1, btn_out=1, toggles=1.
  - Every subsequent toggle spacing lies in 3..10 cycles.
  - done=1 for exactly one cycle, T+65.
  - btn_out=1 stable from T+65 until press changes.
  - busy high for exactly 64 cycles.
- press drops 1->0 at burst cycle 20 and stays 0:
  - Current burst still ends with btn_out=1 and done pulse.
  - busy=0 for one cycle, then a new burst toward 0 ends with btn_out=0.
- bounce_en=0, press toggled 1->0->1 at 5-cycle intervals:
  - btn_out follows with 1-cycle latency.
  - busy=0, done=0, toggles unchanged throughout.
- rstn=0 for one edge at burst cycle 30:
  - Next cycle btn_out=0, busy=0, toggles=0.
  - No done pulse follows.
  - With press still 1, a fresh burst starts on the following edge.
- Parity case: choose a seed producing an even toggle count at the end of the window:
  - Final edge forces btn_out=tgt.
  - toggles reflects the real number of level changes.
